// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared debouncer state encoding and synchroniser depth
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, debounce FSM and press strobe
// Optional auto-repeat while held: define AUTO_REPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
        end
    end

    assign w_btn = r_sync[SYNC_STAGES-1];

    btn_state_e       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             w_press;
    logic             w_repeat;
    logic             r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The sample that leaves a stable state counts as the first of the window,
    // so each wait state needs DEBOUNCE_CYCLES further agreeing samples.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            RELEASED: begin
                if (w_btn) w_state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!w_btn)                 w_state_next = RELEASED;
                else if (r_cnt == CNT_LAST) w_state_next = PRESSED;
                else                        w_cnt_next   = r_cnt + 1'b1;
            end
            PRESSED: begin
                if (!w_btn) w_state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (w_btn)                  w_state_next = PRESSED;
                else if (r_cnt == CNT_LAST) w_state_next = RELEASED;
                else                        w_cnt_next   = r_cnt + 1'b1;
            end
            default: w_state_next = RELEASED;
        endcase
    end

    assign w_press = (r_state == PRESS_WAIT) && (w_state_next == PRESSED);

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(REP_MAX + 1);

    logic [TMR_W-1:0] r_tmr;
    logic             r_first;
    logic             w_hold;
    logic [TMR_W-1:0] w_limit;

    assign w_hold   = (r_state == PRESSED) && (w_state_next == PRESSED);
    assign w_limit  = r_first ? TMR_W'(REPEAT_DELAY - 1) : TMR_W'(REPEAT_PERIOD - 1);
    assign w_repeat = w_hold && (r_tmr == w_limit);

    // Timer only runs across consecutive PRESSED cycles; any exit rearms the long delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr   <= '0;
            r_first <= 1'b1;
        end else if (!w_hold) begin
            r_tmr   <= '0;
            r_first <= 1'b1;
        end else if (w_repeat) begin
            r_tmr   <= '0;
            r_first <= 1'b0;
        end else begin
            r_tmr   <= r_tmr + 1'b1;
        end
    end
`else
    // Repeat parameters are inert in this build; the expression is constant false.
    assign w_repeat = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_press | w_repeat;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_debounce_counter.sv
// rtl/btn_debounce_counter.sv - up/down counter driven by two debounced buttons
// Optional auto-repeat while held: define AUTO_REPEAT_EN.
module btn_debounce_counter #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int WRAP            = 1,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [WIDTH-1:0] count,
    output logic             up_pulse,
    output logic             down_pulse
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             w_up_pulse;
    logic             w_down_pulse;
    logic [WIDTH-1:0] r_count;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_up),
        .o_pulse (w_up_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_down (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_down),
        .o_pulse (w_down_pulse)
    );

    // Coincident strobes cancel; at a limit the count either wraps or holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_up_pulse && !w_down_pulse) begin
            if (r_count != CNT_MAX)  r_count <= r_count + CNT_ONE;
            else if (WRAP != 0)      r_count <= '0;
        end else if (w_down_pulse && !w_up_pulse) begin
            if (r_count != '0)       r_count <= r_count - CNT_ONE;
            else if (WRAP != 0)      r_count <= CNT_MAX;
        end
    end

    assign count      = r_count;
    assign up_pulse   = w_up_pulse;
    assign down_pulse = w_down_pulse;

endmodule

// File: tb/tb_btn_debounce_counter.sv
// tb/tb_btn_debounce_counter.sv - self-checking bench for btn_debounce_counter
module tb_btn_debounce_counter;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic [W-1:0] count_w, count_s;
    logic up_w, dn_w, up_s, dn_s;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btn_debounce_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .WRAP(1),
                           .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_w (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .count(count_w), .up_pulse(up_w), .down_pulse(dn_w));

    btn_debounce_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .WRAP(0),
                           .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_s (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .count(count_s), .up_pulse(up_s), .down_pulse(dn_s));

    // Reference: a level change is accepted after D+1 consecutive disagreeing
    // synchronised samples; the synchroniser is a 2-sample delay.
    int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_age[2];
    bit m_pulse[2];
    int m_cnt_w, m_cnt_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
                m_age[b] = -1; m_pulse[b] = 0;
            end
            m_cnt_w = 0;
            m_cnt_s = 0;
        end else begin
            if (m_pulse[0] && !m_pulse[1]) begin
                m_cnt_w = (m_cnt_w + 1) % 16;
                if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
            end else if (m_pulse[1] && !m_pulse[0]) begin
                m_cnt_w = (m_cnt_w + 15) % 16;
                if (m_cnt_s > 0) m_cnt_s = m_cnt_s - 1;
            end
            for (int b = 0; b < 2; b++) begin
                int d;
                d = m_s2[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = (b == 1) ? int'(btn_down) : int'(btn_up);
                m_pulse[b] = 0;
                if (d != m_lvl[b]) begin
                    if (m_lvl[b] == 1) m_age[b] = -1;
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == D + 1) begin
                        m_lvl[b] = d;
                        m_run[b] = 0;
                        if (d == 1) begin
                            m_pulse[b] = 1;
                            m_age[b] = 0;
                        end
                    end
                end else begin
                    m_run[b] = 0;
`ifdef AUTO_REPEAT_EN
                    if (d == 1) begin
                        if (m_age[b] < 0) m_age[b] = 0;
                        else begin
                            m_age[b] = m_age[b] + 1;
                            if (m_age[b] == RD || (m_age[b] > RD && (m_age[b] - RD) % RP == 0))
                                m_pulse[b] = 1;
                        end
                    end
`endif
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input bit up, input bit dn, input int hold, input int gap);
        btn_up = up;
        btn_down = dn;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (count_w !== 4'd0) begin n_fail++; $display("FAIL reset_count_w got=%0d exp=0", count_w); end
        n_checks++; if (count_s !== 4'd0) begin n_fail++; $display("FAIL reset_count_s got=%0d exp=0", count_s); end
        n_checks++; if (up_w !== 1'b0) begin n_fail++; $display("FAIL reset_up_w got=%0b exp=0", up_w); end
        n_checks++; if (dn_w !== 1'b0) begin n_fail++; $display("FAIL reset_dn_w got=%0b exp=0", dn_w); end
        n_checks++; if (up_s !== 1'b0) begin n_fail++; $display("FAIL reset_up_s got=%0b exp=0", up_s); end
        n_checks++; if (dn_s !== 1'b0) begin n_fail++; $display("FAIL reset_dn_s got=%0b exp=0", dn_s); end
        btn_up = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int npulse;
        npulse = 0;
        btn_up = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (up_w) npulse++;
            n_checks++; if (up_w !== (k == 6)) begin n_fail++; $display("FAIL clean_pulse_k%0d got=%0b exp=%0b", k, up_w, (k == 6)); end
            if (k == 7) begin
                n_checks++; if (count_w !== 4'd1) begin n_fail++; $display("FAIL clean_count_latency got=%0d exp=1", count_w); end
            end
            if (k == 9) btn_up = 1'b0;
        end
        repeat (6) @(negedge clk);
        n_checks++; if (npulse != 1) begin n_fail++; $display("FAIL clean_npulse got=%0d exp=1", npulse); end
        n_checks++; if (count_s !== 4'd1) begin n_fail++; $display("FAIL clean_count_s got=%0d exp=1", count_s); end
    endtask

    task automatic test_bounce();
        int npulse, start;
        int pat[5];
        pat = '{1, 0, 1, 1, 0};
        npulse = 0;
        start = m_cnt_w;
        for (int k = 0; k < 5 + 10 + 12; k++) begin
            btn_up = (k < 5) ? pat[k][0] : (k < 15);
            @(negedge clk);
            if (up_w) npulse++;
            n_checks++; if (up_w !== m_pulse[0]) begin n_fail++; $display("FAIL bounce_pulse_k%0d got=%0b exp=%0b", k, up_w, m_pulse[0]); end
        end
        n_checks++; if (npulse != 1) begin n_fail++; $display("FAIL bounce_npulse got=%0d exp=1", npulse); end
        n_checks++; if (int'(count_w) != (start + 1) % 16) begin n_fail++; $display("FAIL bounce_count got=%0d exp=%0d", count_w, (start + 1) % 16); end
        npulse = 0;
        btn_up = 1'b1;
        repeat (10) begin @(negedge clk); if (up_w) npulse++; end
        for (int g = 1; g <= 3; g++) begin
            btn_up = 1'b0;
            repeat (g) begin @(negedge clk); if (up_w) npulse++; end
            btn_up = 1'b1;
            repeat (6) begin @(negedge clk); if (up_w) npulse++; end
        end
        btn_up = 1'b0;
        repeat (12) begin @(negedge clk); if (up_w) npulse++; end
        n_checks++; if (npulse != 1) begin n_fail++; $display("FAIL glitch_npulse got=%0d exp=1", npulse); end
        n_checks++; if (int'(count_w) != (start + 2) % 16) begin n_fail++; $display("FAIL glitch_count got=%0d exp=%0d", count_w, (start + 2) % 16); end
    endtask

    task automatic test_wrap_sat();
        do_reset();
        repeat (16) press(1'b1, 1'b0, $urandom_range(7, 12), $urandom_range(8, 12));
        n_checks++; if (count_w !== 4'd0) begin n_fail++; $display("FAIL wrap_up got=%0d exp=0", count_w); end
        n_checks++; if (count_s !== 4'd15) begin n_fail++; $display("FAIL sat_up got=%0d exp=15", count_s); end
        press(1'b1, 1'b0, 8, 10);
        n_checks++; if (count_w !== 4'd1) begin n_fail++; $display("FAIL wrap_up_after got=%0d exp=1", count_w); end
        n_checks++; if (count_s !== 4'd15) begin n_fail++; $display("FAIL sat_up_hold got=%0d exp=15", count_s); end
        do_reset();
        press(1'b0, 1'b1, $urandom_range(7, 12), 10);
        n_checks++; if (count_w !== 4'd15) begin n_fail++; $display("FAIL wrap_down got=%0d exp=15", count_w); end
        n_checks++; if (count_s !== 4'd0) begin n_fail++; $display("FAIL sat_down_hold got=%0d exp=0", count_s); end
    endtask

    task automatic test_simultaneous();
        int nup, ndn, nboth;
        nup = 0; ndn = 0; nboth = 0;
        do_reset();
        repeat (7) press(1'b1, 1'b0, 8, 10);
        n_checks++; if (count_w !== 4'd7) begin n_fail++; $display("FAIL simul_pre got=%0d exp=7", count_w); end
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (up_w) nup++;
            if (dn_w) ndn++;
            if (up_w && dn_w) nboth++;
            if (k == 9) begin btn_up = 1'b0; btn_down = 1'b0; end
        end
        n_checks++; if (nboth != 1 || nup != 1 || ndn != 1) begin n_fail++; $display("FAIL simul_pulses got=%0d/%0d/%0d exp=1/1/1", nup, ndn, nboth); end
        n_checks++; if (count_w !== 4'd7) begin n_fail++; $display("FAIL simul_count_w got=%0d exp=7", count_w); end
        n_checks++; if (count_s !== 4'd7) begin n_fail++; $display("FAIL simul_count_s got=%0d exp=7", count_s); end
    endtask

    task automatic test_reset_mid();
        int npulse;
        npulse = 0;
        do_reset();
        btn_up = 1'b1;
        repeat (4) begin @(negedge clk); if (up_w) npulse++; end
        rst_n = 1'b0;
        repeat (3) begin @(negedge clk); if (up_w) npulse++; end
        n_checks++; if (npulse != 0) begin n_fail++; $display("FAIL rstmid_npulse got=%0d exp=0", npulse); end
        n_checks++; if (count_w !== 4'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", count_w); end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++; if (up_w !== (k == 6)) begin n_fail++; $display("FAIL rstmid_pulse_k%0d got=%0b exp=%0b", k, up_w, (k == 6)); end
            if (k == 9) btn_up = 1'b0;
        end
        repeat (8) @(negedge clk);
        n_checks++; if (count_w !== 4'd1) begin n_fail++; $display("FAIL rstmid_count_after got=%0d exp=1", count_w); end
    endtask

    task automatic test_auto_repeat();
        int npulse, first, last;
        npulse = 0; first = -1; last = -1;
        do_reset();
        btn_up = 1'b1;
        for (int k = 0; k < 65; k++) begin
            @(negedge clk);
            if (up_w) begin
                npulse++;
                if (first < 0) first = k;
                last = k;
            end
            if (k == 49) btn_up = 1'b0;
        end
        n_checks++; if (first != 6) begin n_fail++; $display("FAIL repeat_first got=%0d exp=6", first); end
`ifdef AUTO_REPEAT_EN
        n_checks++; if (npulse != 5) begin n_fail++; $display("FAIL repeat_npulse got=%0d exp=5", npulse); end
        n_checks++; if (last != 50) begin n_fail++; $display("FAIL repeat_last got=%0d exp=50", last); end
        n_checks++; if (count_w !== 4'd5) begin n_fail++; $display("FAIL repeat_count got=%0d exp=5", count_w); end
`else
        n_checks++; if (npulse != 1) begin n_fail++; $display("FAIL repeat_npulse got=%0d exp=1", npulse); end
        n_checks++; if (count_w !== 4'd1) begin n_fail++; $display("FAIL repeat_count got=%0d exp=1", count_w); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
            @(negedge clk);
            n_checks++; if (up_w !== m_pulse[0] || up_s !== m_pulse[0]) begin n_fail++; $display("FAIL rand_up_k%0d got=%0b/%0b exp=%0b", k, up_w, up_s, m_pulse[0]); end
            n_checks++; if (dn_w !== m_pulse[1] || dn_s !== m_pulse[1]) begin n_fail++; $display("FAIL rand_dn_k%0d got=%0b/%0b exp=%0b", k, dn_w, dn_s, m_pulse[1]); end
            n_checks++; if (int'(count_w) != m_cnt_w) begin n_fail++; $display("FAIL rand_count_w_k%0d got=%0d exp=%0d", k, count_w, m_cnt_w); end
            n_checks++; if (int'(count_s) != m_cnt_s) begin n_fail++; $display("FAIL rand_count_s_k%0d got=%0d exp=%0d", k, count_s, m_cnt_s); end
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap_sat();
        test_simultaneous();
        test_reset_mid();
        test_auto_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_counter.md
BTN_DEBOUNCE_COUNTER -- requirements
Module: btn_debounce_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, which sets the counter width in bits (legal range 2..32).
REQ-002 The block SHALL take parameter DEBOUNCE_CYCLES, default 1_000_000, the number of consecutive stable clk samples that accept a level change (legal minimum 2).
REQ-003 The block SHALL take parameter WRAP, default 1: 1 selects wrap-around, 0 selects saturation at the count limits.
REQ-004 The block SHALL take parameters REPEAT_DELAY, default 50_000_000, and REPEAT_PERIOD, default 10_000_000; these are used only when AUTO_REPEAT_EN is defined.
REQ-005 The block SHALL have port clk, input, 1 bit, the system clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port btn_up, input, 1 bit, a raw asynchronous active-high button that increments the count.
REQ-008 The block SHALL have port btn_down, input, 1 bit, a raw asynchronous active-high button that decrements the count.
REQ-009 The block SHALL have port count, output, WIDTH bits, the counter value.
REQ-010 The block SHALL have ports up_pulse and down_pulse, output, 1 bit each, a one-cycle accepted-press strobe per button.

Function
REQ-011 Each button input SHALL pass through a 2-flop synchroniser before any other logic.
REQ-012 Each debouncer SHALL implement a 4-state FSM:
- RELEASED to PRESS_WAIT on a synchronised 1.
- PRESS_WAIT to PRESSED after DEBOUNCE_CYCLES consecutive 1 samples.
- PRESS_WAIT to RELEASED on any 0 sample, clearing the stability counter.
- PRESSED to RELEASE_WAIT on a 0 sample.
- RELEASE_WAIT to RELEASED after DEBOUNCE_CYCLES consecutive 0 samples.
- RELEASE_WAIT to PRESSED on any 1 sample.
REQ-013 The pulse SHALL assert for exactly one cycle, on the cycle the FSM enters PRESSED; a bounce during RELEASE_WAIT SHALL NOT produce a pulse.
REQ-014 A clean press SHALL produce a pulse exactly 2 + DEBOUNCE_CYCLES cycles after the first clk edge at which btn is sampled high.
REQ-015 count SHALL update on the clk edge following the pulse, giving a total latency of pulse + 1 cycle.
REQ-016 When WRAP=1, up at 2^WIDTH-1 SHALL give 0, and down at 0 SHALL give 2^WIDTH-1.
REQ-017 When WRAP=0, up at 2^WIDTH-1 and down at 0 SHALL leave count unchanged.
REQ-018 When up_pulse and down_pulse occur in the same cycle, count SHALL remain unchanged.
REQ-019 The stability counter SHALL be sized $clog2(DEBOUNCE_CYCLES+1) and SHALL NOT wrap.

Reset
REQ-020 While rst_n=0: count=0, up_pulse=0, down_pulse=0, all FSMs=RELEASED, synchronisers=0, all timers=0.
REQ-021 Assertion of rst_n mid-debounce or mid-hold SHALL abort the operation without generating a pulse.
REQ-022 After reset release, a button already held SHALL be treated as a new press and debounced in full.

Configuration
REQ-023 Without AUTO_REPEAT_EN, a held button SHALL produce exactly one pulse per press.
REQ-024 With AUTO_REPEAT_EN defined, a button held in PRESSED SHALL emit a further pulse REPEAT_DELAY cycles after the initial pulse, then one pulse every REPEAT_PERIOD cycles until the FSM leaves PRESSED.
REQ-025 With AUTO_REPEAT_EN defined, the repeat timer SHALL reset whenever the FSM leaves PRESSED.

Structure
REQ-026 Package btn_pkg SHALL hold the debouncer state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the synchroniser depth constant (2).
REQ-027 The synchroniser, debounce FSM and repeat timer SHALL live in sub-module btn_debounce, instantiated once per button.
REQ-028 btn_debounce_counter SHALL contain only the two instances and the count datapath.

Verification
Bench settings: WIDTH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
REQ-029 Clean press: btn_up held 10 cycles -> one up_pulse 6 cycles after the first high sample; count goes 0 to 1 on the next edge.
REQ-030 Bounce: btn_up toggles 1,0,1,1,0 and then holds 1 -> exactly one pulse and count=1; glitches of 3 cycles or fewer during release -> no extra pulse.
REQ-031 Wrap and saturation: 16 up presses from 0 with WRAP=1 -> count=0; one down press from 0 -> count=15; repeat with WRAP=0 -> count holds at 15 and at 0 respectively.
REQ-032 Simultaneous: both buttons pressed on the same cycle with count=7 -> both pulses in the same cycle; count stays 7.
REQ-033 Reset mid-operation: rst_n low during PRESS_WAIT -> no pulse, count=0; with the button still held after release -> pulse 6 cycles after the first post-reset sample.
REQ-034 Auto-repeat (AUTO_REPEAT_EN defined): btn_up held 50 cycles -> pulses at t, t+20, t+28, t+36, t+44 and count=5; without the macro -> count=1.
